// File: rtl/ga_engine.sv
// ga_engine: genetic-algorithm core. It holds the population and its fitnesses in
// register arrays and runs init -> evaluate -> breed for each generation. Fitness
// comes from an external evaluator over a valid/ready request and a response
// strobe, so evaluators of any latency can be attached. The core tracks the best
// chromosome seen, supports an early stop on a target fitness, and can carry the
// previous best into the next generation unmodified (elitism).
module ga_engine #(
  parameter int CHROM_WIDTH = 8,   // >= 2, <= 32
  parameter int FIT_WIDTH   = 27,  // signed, larger is better
  parameter int POP_SIZE    = 16,  // power of two, 4..256
  parameter int MUT_SHIFT   = 3,   // per-child mutation probability 1/2^MUT_SHIFT, 1..4
  parameter int ELITE       = 1    // 1: previous best copied into slot 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            seed,
  input  logic                   start,
  input  logic [15:0]            max_gens,
  input  logic [FIT_WIDTH-1:0]   target_fit,
  input  logic                   target_en,
  output logic                   fit_req_valid,
  output logic [CHROM_WIDTH-1:0] fit_req_chrom,
  input  logic                   fit_req_ready,
  input  logic                   fit_rsp_valid,
  input  logic [FIT_WIDTH-1:0]   fit_rsp_fit,
  output logic                   busy,
  output logic                   finished,
  output logic                   early_stop,
  output logic [CHROM_WIDTH-1:0] best,
  output logic [FIT_WIDTH-1:0]   best_fit,
  output logic [15:0]            gen_count
);

  localparam int IDX_W  = $clog2(POP_SIZE);
  localparam int PAIR_W = IDX_W - 1;
  localparam int CUT_W  = $clog2(CHROM_WIDTH);
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic signed [FIT_WIDTH-1:0] FIT_MIN = {1'b1, {(FIT_WIDTH-1){1'b0}}};
  localparam logic [IDX_W-1:0]  LAST_SLOT = IDX_W'(POP_SIZE - 1);
  localparam logic [PAIR_W-1:0] LAST_PAIR = PAIR_W'(POP_SIZE / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_EVAL,
    S_CHECK,
    S_BREED,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [31:0]                   lfsr_q;
  logic [31:0]                   lfsr_step;
  logic [CHROM_WIDTH-1:0]        pop_q [POP_SIZE];
  logic [CHROM_WIDTH-1:0]        nxt_q [POP_SIZE];
  logic signed [FIT_WIDTH-1:0]   fit_q [POP_SIZE];

  logic [IDX_W-1:0]              idx_q;       // INIT write slot / EVAL request slot
  logic                          out_q;       // a request is accepted and awaits its response
  logic [PAIR_W-1:0]             pair_q;      // BREED pair being produced
  logic                          phase_q;     // BREED: 0 = pick parent A, 1 = pick B and write
  logic [IDX_W-1:0]              par_a_q;
  logic [CUT_W-1:0]              cut_q;
  logic [CUT_W-1:0]              mpos0_q;

  logic [CHROM_WIDTH-1:0]        best_q;
  logic signed [FIT_WIDTH-1:0]   best_fit_q;
  logic [15:0]                   gen_q;
  logic [15:0]                   max_gens_q;
  logic signed [FIT_WIDTH-1:0]   target_q;
  logic                          target_en_q;
  logic                          finished_q;
  logic                          early_q;

  logic                          start_acc;
  logic                          req_acc;
  logic                          rsp_acc;
  logic                          last_slot;
  logic [15:0]                   gen_inc;
  logic                          stop_target;
  logic                          stop_count;
  logic                          breed_wr;
  logic                          breed_last;

  logic [IDX_W-1:0]              tour_a, tour_b, tour_win;
  logic [CUT_W-1:0]              mpos1;
  logic [CHROM_WIDTH-1:0]        par_a, par_b, cut_mask, mut0_mask, mut1_mask;
  logic [CHROM_WIDTH-1:0]        child0, child1;

  assign start_acc   = start && (state_q == S_IDLE || state_q == S_DONE);
  assign fit_req_valid = (state_q == S_EVAL) && !out_q;
  assign fit_req_chrom = fit_req_valid ? pop_q[idx_q] : '0;
  assign req_acc     = fit_req_valid && fit_req_ready;
  // A response only counts while a request is outstanding; stray strobes are dropped.
  assign rsp_acc     = (state_q == S_EVAL) && out_q && fit_rsp_valid;
  assign last_slot   = (idx_q == LAST_SLOT);
  assign gen_inc     = gen_q + 16'd1;
  assign stop_target = target_en_q && (best_fit_q >= target_q);
  assign stop_count  = (gen_inc == max_gens_q);
  assign breed_wr    = (state_q == S_BREED) && phase_q;
  assign breed_last  = breed_wr && (pair_q == LAST_PAIR);

  assign busy       = (state_q == S_INIT) || (state_q == S_EVAL) ||
                      (state_q == S_CHECK) || (state_q == S_BREED);
  assign finished   = finished_q;
  assign early_stop = early_q;
  assign best       = best_q;
  assign best_fit   = best_fit_q;
  assign gen_count  = gen_q;

  // Galois LFSR next value (right shift, taps folded in when bit 0 leaves).
  always_comb begin
    lfsr_step = lfsr_q >> 1;
    if (lfsr_q[0]) lfsr_step = (lfsr_q >> 1) ^ LFSR_TAPS;
  end

  // LFSR register: loaded from seed on start, free-running whenever not idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= 32'd1;
    end else if (start_acc) begin
      lfsr_q <= (seed == 32'd0) ? 32'd1 : seed;
    end else if (state_q != S_IDLE) begin
      lfsr_q <= lfsr_step;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic for the generation sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_INIT;
      S_INIT:  if (last_slot) state_d = S_EVAL;
      S_EVAL:  if (rsp_acc && last_slot) state_d = S_CHECK;
      S_CHECK: state_d = (stop_target || stop_count) ? S_DONE : S_BREED;
      S_BREED: if (breed_last) state_d = S_EVAL;
      S_DONE:  if (start) state_d = S_INIT;
      default: state_d = S_IDLE;
    endcase
  end

  // Binary tournament on two random slots: higher fitness wins, ties go to the lower index.
  always_comb begin
    tour_a = lfsr_q[IDX_W-1:0];
    tour_b = lfsr_q[2*IDX_W-1:IDX_W];
    if (fit_q[tour_a] > fit_q[tour_b])      tour_win = tour_a;
    else if (fit_q[tour_b] > fit_q[tour_a]) tour_win = tour_b;
    else                                    tour_win = (tour_a < tour_b) ? tour_a : tour_b;
  end

  // Child construction: single-point crossover then optional one-bit mutation per child.
  // Parent A, the cut and child 0's mutation position were drawn on the previous cycle;
  // parent B, child 1's position and both mutation draws come from the current LFSR value.
  always_comb begin
    mpos1     = CUT_W'({24'd0, lfsr_q[23:16]} % 32'(CHROM_WIDTH));
    par_a     = pop_q[par_a_q];
    par_b     = pop_q[tour_win];
    cut_mask  = (CHROM_WIDTH'(1) << cut_q) - CHROM_WIDTH'(1);
    mut0_mask = '0;
    mut1_mask = '0;
    if (lfsr_q[31 -: MUT_SHIFT] == '0) mut0_mask = CHROM_WIDTH'(1) << mpos0_q;
    if (lfsr_q[27 -: MUT_SHIFT] == '0) mut1_mask = CHROM_WIDTH'(1) << mpos1;
    child0 = ((par_a & ~cut_mask) | (par_b & cut_mask)) ^ mut0_mask;
    child1 = ((par_b & ~cut_mask) | (par_a & cut_mask)) ^ mut1_mask;
    if ((ELITE != 0) && (pair_q == '0)) child0 = best_q;
  end

  // Sequencer datapath: slot/pair counters, handshake flag, best tracking, generation count.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q       <= '0;
      out_q       <= 1'b0;
      pair_q      <= '0;
      phase_q     <= 1'b0;
      par_a_q     <= '0;
      cut_q       <= '0;
      mpos0_q     <= '0;
      best_q      <= '0;
      best_fit_q  <= FIT_MIN;
      gen_q       <= '0;
      max_gens_q  <= 16'd1;
      target_q    <= '0;
      target_en_q <= 1'b0;
      finished_q  <= 1'b0;
      early_q     <= 1'b0;
    end else if (start_acc) begin
      idx_q       <= '0;
      out_q       <= 1'b0;
      pair_q      <= '0;
      phase_q     <= 1'b0;
      best_q      <= '0;
      best_fit_q  <= FIT_MIN;
      gen_q       <= '0;
      max_gens_q  <= (max_gens == 16'd0) ? 16'd1 : max_gens;
      target_q    <= target_fit;
      target_en_q <= target_en;
      finished_q  <= 1'b0;
      early_q     <= 1'b0;
    end else begin
      case (state_q)
        S_INIT: idx_q <= idx_q + 1'b1;
        S_EVAL: begin
          if (req_acc) out_q <= 1'b1;
          if (rsp_acc) begin
            out_q <= 1'b0;
            idx_q <= idx_q + 1'b1;
            // Strictly greater: on a tie the earlier chromosome stays best.
            if ($signed(fit_rsp_fit) > best_fit_q) begin
              best_q     <= pop_q[idx_q];
              best_fit_q <= fit_rsp_fit;
            end
          end
        end
        S_CHECK: begin
          gen_q <= gen_inc;
          if (stop_target) early_q <= 1'b1;
          if (stop_target || stop_count) finished_q <= 1'b1;
        end
        S_BREED: begin
          phase_q <= ~phase_q;
          if (!phase_q) begin
            par_a_q <= tour_win;
            cut_q   <= CUT_W'({24'd0, lfsr_q[23:16]} % 32'(CHROM_WIDTH));
            mpos0_q <= CUT_W'({24'd0, lfsr_q[31:24]} % 32'(CHROM_WIDTH));
          end else begin
            pair_q <= pair_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Population, fitness and next-generation storage; the last pair goes straight into pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < POP_SIZE; j++) begin
        pop_q[j] <= '0;
        nxt_q[j] <= '0;
        fit_q[j] <= '0;
      end
    end else begin
      if (state_q == S_INIT) pop_q[idx_q] <= lfsr_q[CHROM_WIDTH-1:0];
      if (rsp_acc) fit_q[idx_q] <= fit_rsp_fit;
      if (breed_wr) begin
        nxt_q[{pair_q, 1'b0}] <= child0;
        nxt_q[{pair_q, 1'b1}] <= child1;
      end
      if (breed_last) begin
        for (int j = 0; j < POP_SIZE; j++) begin
          if (PAIR_W'(j >> 1) == pair_q) pop_q[j] <= ((j % 2) == 1) ? child1 : child0;
          else                           pop_q[j] <= nxt_q[j];
        end
      end
    end
  end

endmodule
